// File: rtl/trafficlight_pkg.sv
// Shared types and lamp colour constants for the intersection controller.
package trafficlight_pkg;

  // Phase encoding; PH_FLASH is only reachable when NIGHT_FLASH_EN is defined.
  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_CLEAR  = 2'd2,
    PH_FLASH  = 2'd3
  } phase_e;

  // Lamp colours, bit order {r,g,b}.
  localparam logic [2:0] RGB_RED    = 3'b100;
  localparam logic [2:0] RGB_YELLOW = 3'b110;
  localparam logic [2:0] RGB_GREEN  = 3'b010;
  localparam logic [2:0] RGB_OFF    = 3'b000;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: emits a one-cycle strobe every DIV clock cycles.
// The first strobe arrives DIV cycles after reset release.
module tick_prescaler #(
  parameter int DIV = 12000000
) (
  input  logic clk,
  input  logic resn,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..DIV-1 and wrap; never restarted by anything but reset.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Strobe is decoded from the registered count, so it is low in reset.
  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/intersection_ctrl.sv
// Multi-approach traffic-light controller: round-robin green/yellow/all-red
// with latched demand buttons that cut the current green to its minimum.
// Optional night flashing mode is enabled by defining NIGHT_FLASH_EN, which
// adds the 'night' input and the PH_FLASH phase.
// The FSM state is visible on the 'phase' and 'active_dir' outputs.
module intersection_ctrl
  import trafficlight_pkg::*;
#(
  parameter int NUM_DIR     = 2,
  parameter int TICK_DIV    = 12000000,
  parameter int T_GREEN     = 8,
  parameter int T_MIN_GREEN = 2,
  parameter int T_YELLOW    = 2,
  parameter int T_CLEAR     = 1
) (
  input  logic                       clk,
  input  logic                       resn,
  input  logic [NUM_DIR-1:0]         btn,
`ifdef NIGHT_FLASH_EN
  input  logic                       night,
`endif
  output logic [3*NUM_DIR-1:0]       rgb,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output phase_e                     phase,
  output logic                       tick
);

  localparam int DW    = $clog2(NUM_DIR);
  localparam int T_MAX = (T_GREEN > T_YELLOW) ?
                         ((T_GREEN  > T_CLEAR) ? T_GREEN  : T_CLEAR) :
                         ((T_YELLOW > T_CLEAR) ? T_YELLOW : T_CLEAR);
  localparam int TW    = $clog2(T_MAX) + 1;
  localparam logic [DW-1:0] LAST_DIR = DW'(NUM_DIR - 1);

  logic                 w_tick;
  logic                 w_night;
  logic [NUM_DIR-1:0]   r_btn_s1, r_btn_s2, r_btn_d, r_pending;
  logic [NUM_DIR-1:0]   w_edge, w_set, w_clr, w_dir_mask, w_next_mask;
  logic                 w_other_pending;
  phase_e               r_phase, w_phase_n;
  logic [DW-1:0]        r_dir, w_dir_n;
  logic [TW-1:0]        r_timer, w_timer_n;
  logic [31:0]          w_e1;
  logic                 w_enter_green, w_clr_all;
  logic [3*NUM_DIR-1:0] r_rgb, w_rgb_n;

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .resn (resn),
    .tick (w_tick)
  );

`ifdef NIGHT_FLASH_EN
  logic r_night_s1, r_night_s2;

  // Two-flop synchroniser for the asynchronous night input.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_night_s1 <= 1'b0;
      r_night_s2 <= 1'b0;
    end else begin
      r_night_s1 <= night;
      r_night_s2 <= r_night_s1;
    end
  end

  assign w_night = r_night_s2;
`else
  assign w_night = 1'b0;
`endif

  // Two-flop synchroniser plus a delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_btn_d  <= '0;
    end else begin
      r_btn_s1 <= btn;
      r_btn_s2 <= r_btn_s1;
      r_btn_d  <= r_btn_s2;
    end
  end

  assign w_edge = r_btn_s2 & ~r_btn_d;
  assign w_e1   = 32'(r_timer) + 32'd1;

  // One-hot masks of the current and next owning direction.
  always_comb begin
    w_dir_mask  = '0;
    w_next_mask = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      w_dir_mask[i]  = (r_dir == DW'(i));
      w_next_mask[i] = (w_dir_n == DW'(i));
    end
  end

  // A press on the direction that is currently green carries no information.
  assign w_set           = w_edge & ~((r_phase == PH_GREEN) ? w_dir_mask : '0);
  assign w_other_pending = |(r_pending & ~w_dir_mask);
  assign w_clr           = w_clr_all     ? {NUM_DIR{1'b1}} :
                           w_enter_green ? w_next_mask     : '0;

  // Demand latch; clearing on green entry takes priority over a new press.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending | w_set) & ~w_clr;
    end
  end

  // Next-state logic; every transition is qualified by the prescaler tick.
  always_comb begin
    w_phase_n     = r_phase;
    w_dir_n       = r_dir;
    w_timer_n     = r_timer;
    w_enter_green = 1'b0;
    w_clr_all     = 1'b0;
    if (w_tick) begin
      w_timer_n = r_timer + TW'(1);
      if (w_night && (r_phase != PH_FLASH)) begin
        w_phase_n = PH_FLASH;
        w_timer_n = '0;
      end else begin
        case (r_phase)
          PH_GREEN: begin
            if ((w_e1 == 32'(T_GREEN)) ||
                ((w_e1 >= 32'(T_MIN_GREEN)) && w_other_pending)) begin
              w_phase_n = PH_YELLOW;
              w_timer_n = '0;
            end
          end
          PH_YELLOW: begin
            if (w_e1 == 32'(T_YELLOW)) begin
              w_phase_n = PH_CLEAR;
              w_timer_n = '0;
            end
          end
          PH_CLEAR: begin
            if (w_e1 == 32'(T_CLEAR)) begin
              w_phase_n     = PH_GREEN;
              w_timer_n     = '0;
              w_dir_n       = (r_dir == LAST_DIR) ? '0 : r_dir + DW'(1);
              w_enter_green = 1'b1;
            end
          end
          default: begin
            // Flashing: leave once night has dropped, restarting at all-red.
            if (!w_night) begin
              w_phase_n = PH_CLEAR;
              w_timer_n = '0;
              w_clr_all = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Lamp decode from next-state values so lamps register with the phase.
  always_comb begin
    w_rgb_n = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      w_rgb_n[3*i +: 3] = RGB_RED;
      if (w_phase_n == PH_FLASH) begin
        w_rgb_n[3*i +: 3] = w_timer_n[0] ? RGB_OFF : RGB_YELLOW;
      end else if (w_dir_n == DW'(i)) begin
        if (w_phase_n == PH_GREEN) begin
          w_rgb_n[3*i +: 3] = RGB_GREEN;
        end else if (w_phase_n == PH_YELLOW) begin
          w_rgb_n[3*i +: 3] = RGB_YELLOW;
        end
      end
    end
  end

  // State, timer and lamp registers; reset shows all-red ahead of dir 0.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_phase <= PH_CLEAR;
      r_dir   <= LAST_DIR;
      r_timer <= '0;
      r_rgb   <= {NUM_DIR{RGB_RED}};
    end else begin
      r_phase <= w_phase_n;
      r_dir   <= w_dir_n;
      r_timer <= w_timer_n;
      r_rgb   <= w_rgb_n;
    end
  end

  assign rgb        = r_rgb;
  assign active_dir = r_dir;
  assign phase      = r_phase;
  assign tick       = w_tick;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Self-checking bench for intersection_ctrl (NUM_DIR=2, TICK_DIV=4).
// Expected per-cycle lamp/phase/dir/tick words are queued from a segment
// description of the intended sequence, then popped and compared at each
// falling clock edge. Cycle k=0 is the first falling edge after reset release.
module tb_intersection_ctrl;
  import trafficlight_pkg::*;

  localparam int NUM_DIR     = 2;
  localparam int TICK_DIV    = 4;
  localparam int T_GREEN     = 4;
  localparam int T_MIN_GREEN = 1;
  localparam int T_YELLOW    = 2;
  localparam int T_CLEAR     = 1;
  localparam int W           = 10;  // {tick, active_dir, phase[1:0], rgb[5:0]}

  localparam logic [5:0] ALL_RED = 6'b100100;
  localparam logic [5:0] D0_GRN  = 6'b100010;
  localparam logic [5:0] D0_YEL  = 6'b100110;
  localparam logic [5:0] D1_GRN  = 6'b010100;
  localparam logic [5:0] D1_YEL  = 6'b110100;
  localparam logic [5:0] ALL_YEL = 6'b110110;
  localparam logic [5:0] ALL_OFF = 6'b000000;

  logic         clk = 1'b0;
  logic         resn;
  logic [1:0]   btn;
  logic [5:0]   rgb;
  logic         active_dir;
  phase_e       phase;
  logic         tick;
`ifdef NIGHT_FLASH_EN
  logic         night;
`endif

  logic [W-1:0] exp_q[$];
  int           checks  = 0;
  int           errors  = 0;
  int           sched_k = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  intersection_ctrl #(
    .NUM_DIR     (NUM_DIR),
    .TICK_DIV    (TICK_DIV),
    .T_GREEN     (T_GREEN),
    .T_MIN_GREEN (T_MIN_GREEN),
    .T_YELLOW    (T_YELLOW),
    .T_CLEAR     (T_CLEAR)
  ) dut (
    .clk        (clk),
    .resn       (resn),
    .btn        (btn),
`ifdef NIGHT_FLASH_EN
    .night      (night),
`endif
    .rgb        (rgb),
    .active_dir (active_dir),
    .phase      (phase),
    .tick       (tick)
  );

  // Watchdog: the run is short, so this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: assert reset, then release just after a rising edge so the
  // prescaler spends a full cycle at count 0 before the first edge.
  task automatic apply_reset();
    resn = 1'b0;
    btn  = '0;
`ifdef NIGHT_FLASH_EN
    night = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 resn = 1'b1;
    sched_k = 0;
    exp_q.delete();
  endtask

  // Queue n cycles of one lamp/phase/dir segment; tick follows the
  // free-running prescaler (high on every TICK_DIV-th cycle from release).
  task automatic push_seg(input logic [5:0] c, input logic [1:0] ph,
                          input logic d, input int n);
    logic t;
    for (int j = 0; j < n; j++) begin
      t = ((sched_k % TICK_DIV) == (TICK_DIV - 1));
      exp_q.push_back({t, d, ph, c});
      sched_k++;
    end
  endtask

  // Undisturbed sequence from reset: k=0..63.
  task automatic push_free_run();
    push_seg(ALL_RED, PH_CLEAR,  1'b1, 4);
    push_seg(D0_GRN,  PH_GREEN,  1'b0, 16);
    push_seg(D0_YEL,  PH_YELLOW, 1'b0, 8);
    push_seg(ALL_RED, PH_CLEAR,  1'b0, 4);
    push_seg(D1_GRN,  PH_GREEN,  1'b1, 16);
    push_seg(D1_YEL,  PH_YELLOW, 1'b1, 8);
    push_seg(ALL_RED, PH_CLEAR,  1'b1, 4);
    push_seg(D0_GRN,  PH_GREEN,  1'b0, 4);
  endtask

  task automatic test_reset();
    logic [W-1:0] got, exp;
    resn = 1'b0;
    sched_k = 0;
    exp_q.delete();
    push_seg(ALL_RED, PH_CLEAR, 1'b1, 3);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      got = {tick, active_dir, phase, rgb};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset: got %b expected %b", got, exp);
      end
    end
  endtask

  task automatic test_free_run();
    logic [W-1:0] got, exp;
    int k = 0;
    apply_reset();
    push_free_run();
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      got = {tick, active_dir, phase, rgb};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL free_run k=%0d: got %b expected %b", k, got, exp);
      end
      k++;
    end
  endtask

  // btn[1] pressed early in dir0 green cuts it to one tick; dir1 then
  // gets a full green because its demand is cleared on entry.
  task automatic test_demand();
    logic [W-1:0] got, exp;
    int k = 0;
    apply_reset();
    push_seg(ALL_RED, PH_CLEAR,  1'b1, 4);
    push_seg(D0_GRN,  PH_GREEN,  1'b0, 4);
    push_seg(D0_YEL,  PH_YELLOW, 1'b0, 8);
    push_seg(ALL_RED, PH_CLEAR,  1'b0, 4);
    push_seg(D1_GRN,  PH_GREEN,  1'b1, 16);
    push_seg(D1_YEL,  PH_YELLOW, 1'b1, 8);
    push_seg(ALL_RED, PH_CLEAR,  1'b1, 4);
    push_seg(D0_GRN,  PH_GREEN,  1'b0, 4);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      got = {tick, active_dir, phase, rgb};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL demand k=%0d: got %b expected %b", k, got, exp);
      end
      if (k == 4) btn[1] = 1'b1;
      if (k == 7) btn[1] = 1'b0;
      k++;
    end
  endtask

  // btn[0] during dir0 green is ignored: sequence identical to free run.
  task automatic test_btn_green();
    logic [W-1:0] got, exp;
    int k = 0;
    apply_reset();
    push_free_run();
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      got = {tick, active_dir, phase, rgb};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL btn_green k=%0d: got %b expected %b", k, got, exp);
      end
      if (k == 6) btn[0] = 1'b1;
      if (k == 9) btn[0] = 1'b0;
      k++;
    end
  endtask

  // btn[0] during dir0 yellow latches; it shortens dir1 green and is
  // cleared when dir0 regains green, which then runs full length.
  task automatic test_demand_yellow();
    logic [W-1:0] got, exp;
    int k = 0;
    apply_reset();
    push_seg(ALL_RED, PH_CLEAR,  1'b1, 4);
    push_seg(D0_GRN,  PH_GREEN,  1'b0, 16);
    push_seg(D0_YEL,  PH_YELLOW, 1'b0, 8);
    push_seg(ALL_RED, PH_CLEAR,  1'b0, 4);
    push_seg(D1_GRN,  PH_GREEN,  1'b1, 4);
    push_seg(D1_YEL,  PH_YELLOW, 1'b1, 8);
    push_seg(ALL_RED, PH_CLEAR,  1'b1, 4);
    push_seg(D0_GRN,  PH_GREEN,  1'b0, 16);
    push_seg(D0_YEL,  PH_YELLOW, 1'b0, 4);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      got = {tick, active_dir, phase, rgb};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL demand_yellow k=%0d: got %b expected %b", k, got, exp);
      end
      if (k == 20) btn[0] = 1'b1;
      if (k == 23) btn[0] = 1'b0;
      k++;
    end
  endtask

  // Reset pulse mid-yellow: outputs go to reset state without a clock edge.
  task automatic test_reset_mid();
    logic [W-1:0] got, exp;
    int k = 0;
    apply_reset();
    push_seg(ALL_RED, PH_CLEAR,  1'b1, 4);
    push_seg(D0_GRN,  PH_GREEN,  1'b0, 16);
    push_seg(D0_YEL,  PH_YELLOW, 1'b0, 3);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      got = {tick, active_dir, phase, rgb};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_mid_pre k=%0d: got %b expected %b", k, got, exp);
      end
      k++;
    end
    resn = 1'b0;
    #1;
    exp = {1'b0, 1'b1, PH_CLEAR, ALL_RED};
    got = {tick, active_dir, phase, rgb};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_mid_async: got %b expected %b", got, exp);
    end
    @(posedge clk);
    #1 resn = 1'b1;
    sched_k = 0;
    k = 0;
    push_seg(ALL_RED, PH_CLEAR, 1'b1, 4);
    push_seg(D0_GRN,  PH_GREEN, 1'b0, 4);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      got = {tick, active_dir, phase, rgb};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_mid_post k=%0d: got %b expected %b", k, got, exp);
      end
      k++;
    end
  endtask

`ifdef NIGHT_FLASH_EN
  // Night during dir0 green: flash yellow/off per tick, then clear and
  // resume round-robin on dir1.
  task automatic test_night();
    logic [W-1:0] got, exp;
    int k = 0;
    apply_reset();
    push_seg(ALL_RED, PH_CLEAR, 1'b1, 4);
    push_seg(D0_GRN,  PH_GREEN, 1'b0, 4);
    push_seg(ALL_YEL, PH_FLASH, 1'b0, 4);
    push_seg(ALL_OFF, PH_FLASH, 1'b0, 4);
    push_seg(ALL_RED, PH_CLEAR, 1'b0, 4);
    push_seg(D1_GRN,  PH_GREEN, 1'b1, 4);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      got = {tick, active_dir, phase, rgb};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL night k=%0d: got %b expected %b", k, got, exp);
      end
      if (k == 5)  night = 1'b1;
      if (k == 13) night = 1'b0;
      k++;
    end
  endtask
`endif

  initial begin
    resn = 1'b1;
    btn  = '0;
`ifdef NIGHT_FLASH_EN
    night = 1'b0;
`endif
    #2;
    test_reset();
    test_free_run();
    test_demand();
    test_btn_green();
    test_demand_yellow();
    test_reset_mid();
`ifdef NIGHT_FLASH_EN
    test_night();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
